// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC sequencer with a one-deep in-flight tracker and a 2-entry skid buffer feeding decode.
// Optional macro FETCH_RANGE_CHECK_EN stops fetch and raises fetch_fault once pc >= IMEM_BYTES.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] IMEM_BYTES = 32'd32
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instr,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  input  logic        id_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        fetch_fault
);

  typedef enum logic {RUN, FAULT} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        inflight_q, inflight_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] head_instr_q, head_instr_d;
  logic [31:0] head_pc_q, head_pc_d;
  logic [31:0] tail_instr_q, tail_instr_d;
  logic [31:0] tail_pc_q, tail_pc_d;
  logic        fault_q, fault_d;

  logic        pop;
  logic        issue;
  logic        out_of_range;
  logic        range_stop;
  logic [1:0]  count_after_pop;

  assign out_of_range = (pc_q >= IMEM_BYTES);

`ifdef FETCH_RANGE_CHECK_EN
  assign range_stop = out_of_range;
`else
  logic unused_range;
  assign unused_range = out_of_range;
  assign range_stop   = 1'b0;
`endif

  always_comb begin
    pop             = (count_q != 2'd0) & id_ready;
    count_after_pop = count_q - {1'b0, pop};
    issue = !redirect && (state_q == RUN) && !range_stop &&
            (({1'b0, count_after_pop} + {2'b00, inflight_q}) <= 3'd1);

    head_instr_d  = head_instr_q;
    head_pc_d     = head_pc_q;
    tail_instr_d  = tail_instr_q;
    tail_pc_d     = tail_pc_q;
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    state_d       = state_q;
    fault_d       = fault_q;

    // Shift on pop first, then the arrival lands at the first free slot after the pop.
    if (pop) begin
      head_instr_d = tail_instr_q;
      head_pc_d    = tail_pc_q;
    end
    if (inflight_q) begin
      if (count_after_pop == 2'd0) begin
        head_instr_d = imem_instr;
        head_pc_d    = inflight_pc_q;
      end else begin
        tail_instr_d = imem_instr;
        tail_pc_d    = inflight_pc_q;
      end
    end
    count_d = count_after_pop + {1'b0, inflight_q};

    if (issue) begin
      pc_d          = pc_q + 32'd4;
      inflight_d    = 1'b1;
      inflight_pc_d = pc_q;
    end

    if ((state_q == RUN) && range_stop && !redirect) begin
      state_d = FAULT;
      fault_d = 1'b1;
    end

    if (redirect) begin
      count_d    = 2'd0;
      inflight_d = 1'b0;
      pc_d       = {redirect_pc[31:2], 2'b00};
      state_d    = RUN;
      fault_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      count_q       <= 2'd0;
      head_instr_q  <= '0;
      head_pc_q     <= '0;
      tail_instr_q  <= '0;
      tail_pc_q     <= '0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      count_q       <= count_d;
      head_instr_q  <= head_instr_d;
      head_pc_q     <= head_pc_d;
      tail_instr_q  <= tail_instr_d;
      tail_pc_q     <= tail_pc_d;
      fault_q       <= fault_d;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(inflight_q && (count_after_pop == 2'd2)));

  assign imem_pc     = pc_q;
  assign if_valid    = (count_q != 2'd0);
  assign if_instr    = head_instr_q;
  assign if_pc       = head_pc_q;
  assign if_pc_plus4 = head_pc_q + 32'd4;
  assign fetch_fault = fault_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: synchronous memory model plus an expected-PC scoreboard
// consumed on every decode handshake; scenario tasks add their own cycle-level checks.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_pc;
  logic [31:0] imem_instr = '0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        id_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fetch_fault;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_pc;
  logic [31:0] last_pc = '0;
  logic [31:0] mem [8];
  logic [31:0] h_pc, h_instr;

  fetch_ctrl #(.RESET_PC(32'h0000_0000), .IMEM_BYTES(32'd32)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_pc     (imem_pc),
    .imem_instr  (imem_instr),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .if_pc_plus4 (if_pc_plus4),
    .id_ready    (id_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .fetch_fault (fetch_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a < 32'd32) return mem[a[4:2]];
    return '0;
  endfunction

  // 1-cycle-latency instruction store; reads beyond it return 0
  always @(posedge clk) imem_instr <= mem_word(imem_pc);

  // Scoreboard: every handshake must deliver the next expected PC with its memory word
  always @(negedge clk) begin
    if (!reset && if_valid && id_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_underflow: delivered if_pc=%h, no delivery expected", if_pc);
      end else begin
        exp_pc = exp_q.pop_front();
        if (if_pc !== exp_pc || if_instr !== mem_word(exp_pc) || if_pc_plus4 !== exp_pc + 32'd4) begin
          errors++;
          $display("FAIL sb_deliver: got pc=%h instr=%h pc4=%h, expected pc=%h instr=%h pc4=%h",
                   if_pc, if_instr, if_pc_plus4, exp_pc, mem_word(exp_pc), exp_pc + 32'd4);
        end
      end
      last_pc = if_pc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_from(input logic [31:0] a);
    exp_q.delete();
    for (int unsigned i = 0; i < 40; i++) exp_q.push_back(a + 32'(4 * i));
  endtask

  task automatic test_reset();
    reset = 1'b1; id_ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
    repeat (2) tick();
    checks += 6;
    if (imem_pc !== 32'h0) begin errors++; $display("FAIL rst_imem_pc: got %h want 0", imem_pc); end
    if (if_valid !== 1'b0) begin errors++; $display("FAIL rst_if_valid: got %b want 0", if_valid); end
    if (if_instr !== 32'h0) begin errors++; $display("FAIL rst_if_instr: got %h want 0", if_instr); end
    if (if_pc !== 32'h0) begin errors++; $display("FAIL rst_if_pc: got %h want 0", if_pc); end
    if (if_pc_plus4 !== 32'h4) begin errors++; $display("FAIL rst_if_pc_plus4: got %h want 4", if_pc_plus4); end
    if (fetch_fault !== 1'b0) begin errors++; $display("FAIL rst_fault: got %b want 0", fetch_fault); end
    expect_from(32'h0);
    reset = 1'b0;
    tick();
    checks += 2;
    if (imem_pc !== 32'h4) begin errors++; $display("FAIL first_issue_pc: got %h want 4", imem_pc); end
    if (if_valid !== 1'b0) begin errors++; $display("FAIL first_edge_valid: got %b want 0", if_valid); end
    tick();
    checks += 2;
    if (if_valid !== 1'b1) begin errors++; $display("FAIL second_edge_valid: got %b want 1", if_valid); end
    if (if_pc !== 32'h0) begin errors++; $display("FAIL second_edge_pc: got %h want 0", if_pc); end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks += 2;
      if (if_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %b want 1", i, if_valid); end
      if (imem_pc !== if_pc + 32'd8) begin
        errors++; $display("FAIL stream_imem_pc[%0d]: got %h want %h", i, imem_pc, if_pc + 32'd8);
      end
    end
  endtask

  task automatic test_stall();
    redirect = 1'b1; redirect_pc = 32'h0;
    tick();
    redirect = 1'b0;
    expect_from(32'h0);
    repeat (2) tick();
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h0) begin
      errors++; $display("FAIL stall_setup: got valid=%b pc=%h want 1/0", if_valid, if_pc);
    end
    id_ready = 1'b0;
    h_pc = 32'h0; h_instr = mem_word(32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks += 2;
      if (if_valid !== 1'b1 || if_pc !== h_pc || if_instr !== h_instr) begin
        errors++; $display("FAIL stall_hold[%0d]: got valid=%b pc=%h instr=%h want 1/%h/%h",
                           i, if_valid, if_pc, if_instr, h_pc, h_instr);
      end
      if (imem_pc !== h_pc + 32'd8) begin
        errors++; $display("FAIL stall_imem_pc[%0d]: got %h want %h", i, imem_pc, h_pc + 32'd8);
      end
    end
    id_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (if_valid !== 1'b1) begin errors++; $display("FAIL stall_resume[%0d]: got valid=%b want 1", i, if_valid); end
    end
  endtask

  task automatic test_redirect_full();
    redirect = 1'b1; redirect_pc = 32'h0;
    tick();
    redirect = 1'b0;
    expect_from(32'h0);
    repeat (2) tick();
    id_ready = 1'b0;
    tick();
    id_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h14;
    tick();
    redirect = 1'b0;
    expect_from(32'h14);
    checks += 2;
    if (if_valid !== 1'b0) begin errors++; $display("FAIL redir_valid_e: got %b want 0", if_valid); end
    if (imem_pc !== 32'h14) begin errors++; $display("FAIL redir_imem_pc: got %h want 14", imem_pc); end
    tick();
    checks++;
    if (if_valid !== 1'b0) begin errors++; $display("FAIL redir_valid_e1: got %b want 0", if_valid); end
    tick();
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h14) begin
      errors++; $display("FAIL redir_target: got valid=%b pc=%h want 1/14", if_valid, if_pc);
    end
  endtask

  task automatic test_back_to_back();
    repeat (2) tick();
    redirect = 1'b1; redirect_pc = 32'h8;
    tick();
    redirect_pc = 32'h12;
    tick();
    redirect = 1'b0;
    expect_from(32'h10);
    checks++;
    if (if_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid: got %b want 0", if_valid); end
    repeat (2) tick();
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h10) begin
      errors++; $display("FAIL b2b_target: got valid=%b pc=%h want 1/10", if_valid, if_pc);
    end
    repeat (2) tick();
  endtask

  task automatic test_async_reset();
    #2;
    reset = 1'b1;
    expect_from(32'h0);
    #1;
    checks += 5;
    if (imem_pc !== 32'h0) begin errors++; $display("FAIL arst_imem_pc: got %h want 0", imem_pc); end
    if (if_valid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b want 0", if_valid); end
    if (if_pc !== 32'h0) begin errors++; $display("FAIL arst_if_pc: got %h want 0", if_pc); end
    if (if_instr !== 32'h0) begin errors++; $display("FAIL arst_if_instr: got %h want 0", if_instr); end
    if (if_pc_plus4 !== 32'h4) begin errors++; $display("FAIL arst_pc4: got %h want 4", if_pc_plus4); end
    repeat (2) tick();
    reset = 1'b0;
    repeat (2) tick();
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h0) begin
      errors++; $display("FAIL arst_restart: got valid=%b pc=%h want 1/0", if_valid, if_pc);
    end
  endtask

  task automatic test_range();
`ifdef FETCH_RANGE_CHECK_EN
    redirect = 1'b1; redirect_pc = 32'h10;
    tick();
    redirect = 1'b0;
    expect_from(32'h10);
    for (int i = 0; i < 16 && fetch_fault !== 1'b1; i++) tick();
    checks++;
    if (fetch_fault !== 1'b1) begin errors++; $display("FAIL range_fault: got %b want 1", fetch_fault); end
    repeat (4) tick();
    checks += 3;
    if (if_valid !== 1'b0) begin errors++; $display("FAIL range_valid: got %b want 0", if_valid); end
    if (last_pc !== 32'h1C) begin errors++; $display("FAIL range_last: got %h want 1c", last_pc); end
    if (imem_pc !== 32'h20) begin errors++; $display("FAIL range_imem_pc: got %h want 20", imem_pc); end
    redirect = 1'b1; redirect_pc = 32'h8;
    tick();
    redirect = 1'b0;
    expect_from(32'h8);
    checks++;
    if (fetch_fault !== 1'b0) begin errors++; $display("FAIL range_clear: got %b want 0", fetch_fault); end
    repeat (2) tick();
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h8) begin
      errors++; $display("FAIL range_refetch: got valid=%b pc=%h want 1/8", if_valid, if_pc);
    end
`else
    redirect = 1'b1; redirect_pc = 32'h18;
    tick();
    redirect = 1'b0;
    expect_from(32'h18);
    for (int i = 0; i < 12 && !(if_valid === 1'b1 && if_pc === 32'h20); i++) tick();
    checks += 2;
    if (if_valid !== 1'b1 || if_pc !== 32'h20 || if_instr !== 32'h0) begin
      errors++; $display("FAIL beyond_store: got valid=%b pc=%h instr=%h want 1/20/0", if_valid, if_pc, if_instr);
    end
    if (fetch_fault !== 1'b0) begin errors++; $display("FAIL beyond_fault: got %b want 0", fetch_fault); end
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int unsigned i = 0; i < 8; i++) mem[i] = 32'hC0DE_0000 + 32'(i) * 32'h0101_0103;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_full();
    test_back_to_back();
    test_async_reset();
    test_range();
    id_ready = 1'b0;
    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
